// File: rtl/cmp_tally_pkg.sv
// Shared definitions for cmp_tally: comparator result codes, FSM state encoding
// and the reserved result bit.
package cmp_tally_pkg;

  localparam logic [2:0] CMP_LT = 3'b001;
  localparam logic [2:0] CMP_EQ = 3'b010;
  localparam logic [2:0] CMP_GT = 3'b100;

  localparam int RSV_BIT = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COUNT  = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

  function automatic logic is_onehot3(input logic [2:0] c);
    return (c == CMP_LT) || (c == CMP_EQ) || (c == CMP_GT);
  endfunction

endpackage

// File: rtl/cmp_tally_sat_counter.sv
// sat_counter: synchronous-clear up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_reg;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q_reg <= '0;
    end else if (inc && (q_reg != {W{1'b1}})) begin
      q_reg <= q_reg + W'(1);
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/cmp_tally.sv
// cmp_tally: tallies comparator results over a window of WINDOW samples and offers a report.
// Optional longest-GT-run tracking is built when CMP_TALLY_STREAK_EN is defined.
module cmp_tally
  import cmp_tally_pkg::*;
#(
  parameter int CNT_W  = 8,
  parameter int WINDOW = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       r_in,
  input  logic             r_valid,
  output logic             busy,
  output logic [CNT_W-1:0] lt_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] streak_max,
  output logic             rpt_valid,
  input  logic             rpt_ready
);

  localparam int IDX_W = $clog2(WINDOW + 1);

  state_t           state_reg;
  state_t           state_next;
  logic [IDX_W-1:0] idx_reg;
  logic [2:0]       code;
  logic             clr;
  logic             take;
  logic             last_sample;
  logic [3:0]       inc_vec;
  logic [CNT_W-1:0] cnt_q [4];
  logic             unused_rsv;

  assign code        = r_in[2:0];
  assign unused_rsv  = r_in[RSV_BIT];
  assign clr         = (state_reg == ST_IDLE) && start;
  assign take        = (state_reg == ST_COUNT) && r_valid;
  assign last_sample = take && (idx_reg == IDX_W'(WINDOW - 1));

  // Order: lt, eq, gt, err
  assign inc_vec[0] = take && (code == CMP_LT);
  assign inc_vec[1] = take && (code == CMP_EQ);
  assign inc_vec[2] = take && (code == CMP_GT);
  assign inc_vec[3] = take && !is_onehot3(code);

  for (genvar gi = 0; gi < 4; gi++) begin : g_tally
    sat_counter #(.W(CNT_W)) u_cnt (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .inc (inc_vec[gi]),
      .q   (cnt_q[gi])
    );
  end

  assign lt_cnt  = cnt_q[0];
  assign eq_cnt  = cnt_q[1];
  assign gt_cnt  = cnt_q[2];
  assign err_cnt = cnt_q[3];

`ifdef CMP_TALLY_STREAK_EN
  logic [CNT_W-1:0] run_q;
  logic [CNT_W-1:0] max_q;

  sat_counter #(.W(CNT_W)) u_run (
    .clk (clk),
    .rst (rst),
    .clr (clr || (take && (code != CMP_GT))),
    .inc (inc_vec[2]),
    .q   (run_q)
  );

  // The max only grows when the current run is the longest seen and extends by one.
  sat_counter #(.W(CNT_W)) u_max (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (inc_vec[2] && (run_q == max_q)),
    .q   (max_q)
  );

  assign streak_max = max_q;
`else
  assign streak_max = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_reg <= '0;
    end else if (clr) begin
      idx_reg <= '0;
    end else if (take) begin
      idx_reg <= idx_reg + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (start)       state_next = ST_COUNT;
      ST_COUNT:  if (last_sample) state_next = ST_REPORT;
      ST_REPORT: if (rpt_ready)   state_next = ST_IDLE;
      default:                    state_next = ST_IDLE;
    endcase
  end

  assign busy      = (state_reg == ST_COUNT) || (state_reg == ST_REPORT);
  assign rpt_valid = (state_reg == ST_REPORT);

endmodule

// File: tb/tb_cmp_tally.sv
// Scoreboard bench for cmp_tally: three instances (WINDOW 4, 20, 6; CNT_W 4) driven one at a time.
module tb_cmp_tally;

  localparam int CNT_W = 4;
  localparam int SAT   = 15;
`ifdef CMP_TALLY_STREAK_EN
  localparam int STREAK_ON = 1;
`else
  localparam int STREAK_ON = 0;
`endif

  typedef struct {
    int k;
    int lt;
    int eq;
    int gt;
    int err;
    int smax;
  } exp_t;

  logic clk;
  logic             rst_a       [3];
  logic             start_a     [3];
  logic [3:0]       r_in_a      [3];
  logic             r_valid_a   [3];
  logic             rpt_ready_a [3];
  logic             busy_a      [3];
  logic             rpt_valid_a [3];
  logic [CNT_W-1:0] lt_a        [3];
  logic [CNT_W-1:0] eq_a        [3];
  logic [CNT_W-1:0] gt_a        [3];
  logic [CNT_W-1:0] err_a       [3];
  logic [CNT_W-1:0] smax_a      [3];

  int n_checks = 0;
  int n_fail   = 0;

  exp_t sbq[$];
  exp_t last_exp [3];
  int   m_lt [3], m_eq [3], m_gt [3], m_err [3], m_run [3], m_max [3], m_n [3];
  bit   m_counting [3];

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    cmp_tally #(.CNT_W(CNT_W), .WINDOW(gi == 0 ? 4 : (gi == 1 ? 20 : 6))) u_dut (
      .clk        (clk),
      .rst        (rst_a[gi]),
      .start      (start_a[gi]),
      .r_in       (r_in_a[gi]),
      .r_valid    (r_valid_a[gi]),
      .busy       (busy_a[gi]),
      .lt_cnt     (lt_a[gi]),
      .eq_cnt     (eq_a[gi]),
      .gt_cnt     (gt_a[gi]),
      .err_cnt    (err_a[gi]),
      .streak_max (smax_a[gi]),
      .rpt_valid  (rpt_valid_a[gi]),
      .rpt_ready  (rpt_ready_a[gi])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int win(input int k);
    return (k == 0) ? 4 : ((k == 1) ? 20 : 6);
  endfunction

  function automatic int sat(input int x);
    return (x > SAT) ? SAT : x;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_clear(input int k);
    m_lt[k] = 0; m_eq[k] = 0; m_gt[k] = 0; m_err[k] = 0;
    m_run[k] = 0; m_max[k] = 0; m_n[k] = 0;
  endtask

  task automatic model_sample(input int k, input logic [3:0] code);
    exp_t e;
    if (!m_counting[k]) return;
    case (code[2:0])
      3'b001:  m_lt[k]++;
      3'b010:  m_eq[k]++;
      3'b100:  m_gt[k]++;
      default: m_err[k]++;
    endcase
    if (code[2:0] == 3'b100) begin
      m_run[k]++;
      if (m_run[k] > m_max[k]) m_max[k] = m_run[k];
    end else begin
      m_run[k] = 0;
    end
    m_n[k]++;
    if (m_n[k] == win(k)) begin
      e.k = k; e.lt = sat(m_lt[k]); e.eq = sat(m_eq[k]); e.gt = sat(m_gt[k]);
      e.err = sat(m_err[k]); e.smax = STREAK_ON ? sat(m_max[k]) : 0;
      sbq.push_back(e);
      last_exp[k] = e;
      m_counting[k] = 1'b0;
      $display("window done: inst %0d lt=%0d eq=%0d gt=%0d err=%0d streak=%0d",
               k, e.lt, e.eq, e.gt, e.err, e.smax);
    end
  endtask

  task automatic do_reset(input int k);
    rst_a[k] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_a[k] = 1'b0;
    model_clear(k);
    m_counting[k] = 1'b0;
  endtask

  task automatic do_start(input int k);
    start_a[k] = 1'b1;
    @(posedge clk);
    #1;
    start_a[k] = 1'b0;
    model_clear(k);
    m_counting[k] = 1'b1;
    chk("busy_after_start", int'(busy_a[k]), 1);
  endtask

  task automatic send(input int k, input logic [3:0] code, input logic valid);
    r_in_a[k]    = code;
    r_valid_a[k] = valid;
    @(posedge clk);
    #1;
    r_valid_a[k] = 1'b0;
    if (valid) model_sample(k, code);
  endtask

  task automatic check_zero(input int k);
    chk("rst_busy", int'(busy_a[k]), 0);
    chk("rst_rpt_valid", int'(rpt_valid_a[k]), 0);
    chk("rst_tallies", int'(lt_a[k]) + int'(eq_a[k]) + int'(gt_a[k]) + int'(err_a[k]), 0);
    chk("rst_streak", int'(smax_a[k]), 0);
  endtask

  // Lets any pending report drain, with rpt_ready toggled randomly.
  task automatic wait_idle(input int k, input bit rand_ready);
    int cyc = 0;
    while (busy_a[k] !== 1'b0 && cyc < 60) begin
      if (rand_ready) rpt_ready_a[k] = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      cyc++;
    end
    rpt_ready_a[k] = 1'b1;
    chk("wait_idle_timeout", int'(cyc < 60), 1);
  endtask

  function automatic logic [3:0] rand_code();
    logic [3:0] c;
    case ($urandom_range(0, 3))
      0: c = {1'($urandom_range(0, 1)), 3'b001};
      1: c = {1'($urandom_range(0, 1)), 3'b010};
      2: c = {1'($urandom_range(0, 1)), 3'b100};
      default: c = 4'($urandom_range(0, 15));
    endcase
    return c;
  endfunction

  // Monitor: every accepted report is popped from the scoreboard and compared.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rpt_valid_a[k] === 1'b1 && rpt_ready_a[k] === 1'b1) begin
        if (sbq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_report: inst %0d got report expected none", k);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("rpt_inst", k, e.k);
          chk("rpt_lt", int'(lt_a[k]), e.lt);
          chk("rpt_eq", int'(eq_a[k]), e.eq);
          chk("rpt_gt", int'(gt_a[k]), e.gt);
          chk("rpt_err", int'(err_a[k]), e.err);
          chk("rpt_streak", int'(smax_a[k]), e.smax);
          chk("rpt_busy", int'(busy_a[k]), 1);
          if (e.lt < SAT && e.eq < SAT && e.gt < SAT && e.err < SAT)
            chk("rpt_sum", e.lt + e.eq + e.gt + e.err, win(k));
          $display("report: inst %0d lt=%0d eq=%0d gt=%0d err=%0d streak=%0d",
                   k, lt_a[k], eq_a[k], gt_a[k], err_a[k], smax_a[k]);
        end
      end
    end
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst_a[k] = 1'b1; start_a[k] = 1'b0; r_in_a[k] = 4'h0;
      r_valid_a[k] = 1'b0; rpt_ready_a[k] = 1'b1;
      model_clear(k);
      m_counting[k] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) rst_a[k] = 1'b0;
    for (int k = 0; k < 3; k++) check_zero(k);

    // Basic window: GT, LT, EQ, GT
    do_start(0);
    send(0, 4'b0100, 1'b1);
    send(0, 4'b0001, 1'b1);
    send(0, 4'b0010, 1'b1);
    send(0, 4'b0100, 1'b1);
    chk("basic_latency", int'(rpt_valid_a[0]), 1);
    chk("basic_lt", int'(lt_a[0]), 1);
    chk("basic_eq", int'(eq_a[0]), 1);
    chk("basic_gt", int'(gt_a[0]), 2);
    chk("basic_err", int'(err_a[0]), 0);
    @(posedge clk);
    #1;
    chk("basic_idle_busy", int'(busy_a[0]), 0);
    chk("basic_idle_rpt_valid", int'(rpt_valid_a[0]), 0);
    chk("basic_idle_hold_gt", int'(gt_a[0]), 2);

    // Invalid codes and a gap; bit 3 is ignored
    do_start(0);
    send(0, 4'b0011, 1'b1);
    send(0, 4'b0100, 1'b0);
    send(0, 4'b0000, 1'b1);
    send(0, 4'b0010, 1'b1);
    send(0, 4'b1100, 1'b1);
    chk("inv_rpt_valid", int'(rpt_valid_a[0]), 1);
    chk("inv_err", int'(err_a[0]), 2);
    chk("inv_eq", int'(eq_a[0]), 1);
    chk("inv_gt", int'(gt_a[0]), 1);
    wait_idle(0, 1'b0);

    // Backpressure: report held while r_valid and start are driven
    rpt_ready_a[0] = 1'b0;
    do_start(0);
    for (int i = 0; i < 4; i++) send(0, rand_code(), 1'b1);
    for (int i = 0; i < 5; i++) begin
      r_valid_a[0] = 1'b1;
      start_a[0]   = 1'b1;
      r_in_a[0]    = rand_code();
      @(posedge clk);
      #1;
      chk("bp_rpt_valid", int'(rpt_valid_a[0]), 1);
      chk("bp_lt", int'(lt_a[0]), last_exp[0].lt);
      chk("bp_eq", int'(eq_a[0]), last_exp[0].eq);
      chk("bp_gt", int'(gt_a[0]), last_exp[0].gt);
      chk("bp_err", int'(err_a[0]), last_exp[0].err);
    end
    r_valid_a[0]   = 1'b0;
    rpt_ready_a[0] = 1'b1;
    @(posedge clk);
    #1;
    start_a[0] = 1'b0;
    chk("bp_release_busy", int'(busy_a[0]), 0);
    chk("bp_release_rpt_valid", int'(rpt_valid_a[0]), 0);
    @(posedge clk);
    #1;
    chk("bp_start_dropped", int'(busy_a[0]), 0);

    // Saturation: 20 GT samples with 4-bit tallies
    do_start(1);
    for (int i = 0; i < 20; i++) send(1, 4'b0100, 1'b1);
    chk("sat_rpt_valid", int'(rpt_valid_a[1]), 1);
    chk("sat_gt", int'(gt_a[1]), 15);
    wait_idle(1, 1'b0);

    // Reset in mid-window, then a normal window
    do_start(0);
    send(0, 4'b0001, 1'b1);
    send(0, 4'b0100, 1'b1);
    do_reset(0);
    check_zero(0);
    do_start(0);
    for (int i = 0; i < 4; i++) send(0, rand_code(), 1'b1);
    chk("post_rst_rpt_valid", int'(rpt_valid_a[0]), 1);
    wait_idle(0, 1'b0);

    // Streak: GT,GT,LT,GT,gap,GT,GT
    do_start(2);
    send(2, 4'b0100, 1'b1);
    send(2, 4'b0100, 1'b1);
    send(2, 4'b0001, 1'b1);
    send(2, 4'b0100, 1'b1);
    send(2, 4'b0001, 1'b0);
    send(2, 4'b0100, 1'b1);
    send(2, 4'b0100, 1'b1);
    chk("streak_rpt_valid", int'(rpt_valid_a[2]), 1);
    chk("streak_max", int'(smax_a[2]), STREAK_ON ? 3 : 0);
    chk("streak_gt", int'(gt_a[2]), 5);
    wait_idle(2, 1'b0);

    // Random windows with gaps and random backpressure
    for (int w = 0; w < 24; w++) begin
      int k;
      int guard;
      k = (w % 3 == 2) ? 2 : 0;
      do_start(k);
      guard = 0;
      while (m_counting[k] && guard < 200) begin
        send(k, rand_code(), 1'($urandom_range(0, 3) != 0));
        guard++;
      end
      chk("rand_window_done", int'(m_counting[k]), 0);
      wait_idle(k, 1'b1);
    end

    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_drained", sbq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
